// File: rtl/uart_rx_fifo.sv
// Buffered UART 8N1 receiver: synchronizer, mid-bit sampling FSM and a show-ahead
// byte FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int HALF = DELAY_FRAMES / 2;
  localparam int CW   = $clog2(DELAY_FRAMES) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;

  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_next;
  logic [7:0]    head_next;
  logic [7:0]    mem [FIFO_DEPTH];

  // Idle-high line: synchronizer flops reset to 1 so reset release never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt  <= '0;
            bitn <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= '0;
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // A held-low line stays here, so it reports one frame error and never restarts.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push     = (state == STOP) && (cnt == CNT_LAST) && rx_s;
  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (fifo_count == DEPTH);
  assign push_ok  = push && (!full || pop);
  assign rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = fifo_count;
    case ({push_ok, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  // The new head is the byte being written this cycle when it lands at the read pointer.
  always_comb begin
    head_next = rx_data;
    if (count_next != '0) begin
      if (push_ok && (rd_next == wr_ptr)) head_next = shreg;
      else                                head_next = mem[rd_next];
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_next;
      fifo_count <= count_next;
      rx_data    <= head_next;
      overflow   <= push && full && !pop;
    end
  end

endmodule
